issue_scoreboard_super: RTL and testbench

//  Dual-issue in-order issue stage for the two-pipe (alp/bta) core. Directly upstream of the 32x32 register file.

---
 rtl/issue_scoreboard_super_pkg.sv | 24 ++
 rtl/issue_scoreboard_super_sb_busy_vec.sv | 55 +++++
 rtl/issue_scoreboard_super.sv | 157 +++++++++++++++
 tb/tb_issue_scoreboard_super.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_super_pkg.sv
// Shared definitions for the dual-issue scoreboard: register address width,
// register count, the hard-wired zero register and the issue-window entry layout.
package issue_scoreboard_super_pkg;

    localparam int AW   = 5;
    localparam int NREG = 32;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    // One issue-window entry, payload held separately because its width is a
    // top-level parameter. Field order fixes the packed bit offsets:
    // rd [4:0], rs2 [9:5], rs1 [14:10], wrd [15], use2 [16], use1 [17].
    typedef struct packed {
        logic          use1;
        logic          use2;
        logic          wrd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
    } win_entry_t;

    localparam win_entry_t ENTRY_ZERO = 18'd0;

endpackage

// File: rtl/issue_scoreboard_super_sb_busy_vec.sv
// sb_busy_vec: per-register busy bits for the issue stage.
//   set_en/set_addr   : mark a register busy (issued writer), 2 ports
//   clr_en/clr_addr   : clear a register (writeback), 2 ports
//   rd_addr/rd_busy   : NRD read ports; a register being cleared this cycle
//                       reads as not busy (the RF writes on the falling edge)
// Set wins over clear on the same register; register 0 is never busy.
module sb_busy_vec
    import issue_scoreboard_super_pkg::*;
#(
    parameter int NRD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             set_en,
    input  logic [1:0][AW-1:0]     set_addr,
    input  logic [1:0]             clr_en,
    input  logic [1:0][AW-1:0]     clr_addr,
    input  logic [NRD-1:0][AW-1:0] rd_addr,
    output logic [NRD-1:0]         rd_busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Next busy vector: clears first, then sets so a set overrides a clear.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < 2; i++) begin
            busy_nxt_s[clr_addr[i]] = busy_nxt_s[clr_addr[i]] & ~clr_en[i];
        end
        for (int i = 0; i < 2; i++) begin
            busy_nxt_s[set_addr[i]] = busy_nxt_s[set_addr[i]] | set_en[i];
        end
        busy_nxt_s[ZERO_REG] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports with same-cycle writeback bypass.
    always_comb begin
        for (int j = 0; j < NRD; j++) begin
            rd_busy[j] = busy_r[rd_addr[j]]
                         & ~(clr_en[0] & (clr_addr[0] == rd_addr[j]))
                         & ~(clr_en[1] & (clr_addr[1] == rd_addr[j]));
        end
    end

endmodule

// File: rtl/issue_scoreboard_super.sv
// issue_scoreboard_super: dual-issue in-order issue stage (alp/bta pipes).
//   clk, reset (async active-low), flush (sync window clear)
//   dec_*        : decoded pair, slot0 (older) in the low bits
//   dec_ready    : pair accepted when dec_ready & |dec_valid
//   wb_*_alp/bta : active-low writeback strobes + addresses, clear busy bits
//   iss_valid_*  : issue strobes; rd*_addr_* RF read addresses (0 if unused)
//   iss_rd_*, iss_pld_* : destination and payload of issued instructions
//   issue_cnt    : running count of issued instructions
// Issue outputs are combinational from the window and busy state so that a
// same-cycle writeback can release a waiting instruction.
module issue_scoreboard_super
    import issue_scoreboard_super_pkg::*;
#(
    parameter int PLD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         dec_valid,
    output logic               dec_ready,
    input  logic [2*AW-1:0]    dec_rs1,
    input  logic [2*AW-1:0]    dec_rs2,
    input  logic [2*AW-1:0]    dec_rd,
    input  logic [1:0]         dec_use1,
    input  logic [1:0]         dec_use2,
    input  logic [1:0]         dec_wrd,
    input  logic [2*PLD_W-1:0] dec_pld,
    input  logic               wb_wr_n_alp,
    input  logic [AW-1:0]      wb_addr_alp,
    input  logic               wb_wr_n_bta,
    input  logic [AW-1:0]      wb_addr_bta,
    output logic               iss_valid_alp,
    output logic               iss_valid_bta,
    output logic [AW-1:0]      rd1_addr_alp,
    output logic [AW-1:0]      rd2_addr_alp,
    output logic [AW-1:0]      rd1_addr_bta,
    output logic [AW-1:0]      rd2_addr_bta,
    output logic [AW-1:0]      iss_rd_alp,
    output logic [AW-1:0]      iss_rd_bta,
    output logic [PLD_W-1:0]   iss_pld_alp,
    output logic [PLD_W-1:0]   iss_pld_bta,
    output logic [31:0]        issue_cnt
);

    win_entry_t [1:0]            ent_r;
    logic [1:0]                  vld_r;
    logic [1:0][PLD_W-1:0]       pld_r;
    logic [31:0]                 issue_cnt_r;

    win_entry_t [1:0]            dec_ent_s;
    logic [5:0][AW-1:0]          busy_addr_s;
    logic [5:0]                  busy_s;
    logic                        ok0_s;
    logic                        ok1_s;
    logic                        hazard_s;
    logic                        iss_alp_s;
    logic                        iss_bta_s;
    logic                        all_issue_s;
    logic                        dec_ready_s;
    logic                        accept_s;

    // Unpack the decoded pair into window-entry form.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            dec_ent_s[s].use1 = dec_use1[s];
            dec_ent_s[s].use2 = dec_use2[s];
            dec_ent_s[s].wrd  = dec_wrd[s];
            dec_ent_s[s].rs1  = dec_rs1[s*AW +: AW];
            dec_ent_s[s].rs2  = dec_rs2[s*AW +: AW];
            dec_ent_s[s].rd   = dec_rd[s*AW +: AW];
        end
    end

    assign busy_addr_s[0] = ent_r[0].rs1;
    assign busy_addr_s[1] = ent_r[0].rs2;
    assign busy_addr_s[2] = ent_r[1].rs1;
    assign busy_addr_s[3] = ent_r[1].rs2;
    assign busy_addr_s[4] = ent_r[0].rd;
    assign busy_addr_s[5] = ent_r[1].rd;

    sb_busy_vec #(
        .NRD (6)
    ) u_busy (
        .clk      (clk),
        .reset    (reset),
        .set_en   ({iss_bta_s & ent_r[1].wrd, iss_alp_s & ent_r[0].wrd}),
        .set_addr ({ent_r[1].rd, ent_r[0].rd}),
        .clr_en   ({~wb_wr_n_bta, ~wb_wr_n_alp}),
        .clr_addr ({wb_addr_bta, wb_addr_alp}),
        .rd_addr  (busy_addr_s),
        .rd_busy  (busy_s)
    );

    // Hazard checks and issue decisions; r0 never reads as busy.
    always_comb begin
        ok0_s = (~ent_r[0].use1 | ~busy_s[0])
              & (~ent_r[0].use2 | ~busy_s[1])
              & (~ent_r[0].wrd  | ~busy_s[4]);
        ok1_s = (~ent_r[1].use1 | ~busy_s[2])
              & (~ent_r[1].use2 | ~busy_s[3])
              & (~ent_r[1].wrd  | ~busy_s[5]);
        hazard_s = ent_r[0].wrd & (ent_r[0].rd != ZERO_REG)
                 & ((ent_r[1].use1 & (ent_r[1].rs1 == ent_r[0].rd))
                  | (ent_r[1].use2 & (ent_r[1].rs2 == ent_r[0].rd))
                  | (ent_r[1].rd == ent_r[0].rd));
        iss_alp_s   = ~flush & vld_r[0] & ok0_s;
        iss_bta_s   = iss_alp_s & vld_r[1] & ok1_s & ~hazard_s;
        // slot1 is only ever valid with slot0, so an empty window passes here
        all_issue_s = (~vld_r[0] | iss_alp_s) & (~vld_r[1] | iss_bta_s);
        dec_ready_s = ~flush & all_issue_s;
        accept_s    = dec_ready_s & (|dec_valid);
    end

    // Issue window: flush, then accept, then compaction after alp-only issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r <= 2'b00;
            ent_r <= {ENTRY_ZERO, ENTRY_ZERO};
            pld_r <= {2{{PLD_W{1'b0}}}};
        end else if (flush) begin
            vld_r <= 2'b00;
        end else if (accept_s) begin
            vld_r <= dec_valid;
            ent_r <= dec_ent_s;
            pld_r <= dec_pld;
        end else if (iss_alp_s) begin
            ent_r[0] <= ent_r[1];
            pld_r[0] <= pld_r[1];
            vld_r    <= {1'b0, vld_r[1] & ~iss_bta_s};
        end else begin
            vld_r <= vld_r;
        end
    end

    // Issued-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt_r <= 32'd0;
        end else begin
            issue_cnt_r <= issue_cnt_r + {31'd0, iss_alp_s} + {31'd0, iss_bta_s};
        end
    end

    assign dec_ready     = dec_ready_s;
    assign iss_valid_alp = iss_alp_s;
    assign iss_valid_bta = iss_bta_s;
    assign rd1_addr_alp  = (vld_r[0] & ent_r[0].use1) ? ent_r[0].rs1 : ZERO_REG;
    assign rd2_addr_alp  = (vld_r[0] & ent_r[0].use2) ? ent_r[0].rs2 : ZERO_REG;
    assign rd1_addr_bta  = (vld_r[1] & ent_r[1].use1) ? ent_r[1].rs1 : ZERO_REG;
    assign rd2_addr_bta  = (vld_r[1] & ent_r[1].use2) ? ent_r[1].rs2 : ZERO_REG;
    assign iss_rd_alp    = iss_alp_s ? ent_r[0].rd : ZERO_REG;
    assign iss_rd_bta    = iss_bta_s ? ent_r[1].rd : ZERO_REG;
    assign iss_pld_alp   = iss_alp_s ? pld_r[0] : {PLD_W{1'b0}};
    assign iss_pld_bta   = iss_bta_s ? pld_r[1] : {PLD_W{1'b0}};
    assign issue_cnt     = issue_cnt_r;

endmodule

// File: tb/tb_issue_scoreboard_super.sv
// Directed self-checking bench for issue_scoreboard_super.
module tb_issue_scoreboard_super;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  dec_valid;
    logic        dec_ready;
    logic [9:0]  dec_rs1, dec_rs2, dec_rd;
    logic [1:0]  dec_use1, dec_use2, dec_wrd;
    logic [63:0] dec_pld;
    logic        wb_wr_n_alp, wb_wr_n_bta;
    logic [4:0]  wb_addr_alp, wb_addr_bta;
    logic        iss_valid_alp, iss_valid_bta;
    logic [4:0]  rd1_addr_alp, rd2_addr_alp, rd1_addr_bta, rd2_addr_bta;
    logic [4:0]  iss_rd_alp, iss_rd_bta;
    logic [31:0] iss_pld_alp, iss_pld_bta;
    logic [31:0] issue_cnt;

    int n_checks = 0;
    int n_errors = 0;

    issue_scoreboard_super #(.PLD_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_rd        (dec_rd),
        .dec_use1      (dec_use1),
        .dec_use2      (dec_use2),
        .dec_wrd       (dec_wrd),
        .dec_pld       (dec_pld),
        .wb_wr_n_alp   (wb_wr_n_alp),
        .wb_addr_alp   (wb_addr_alp),
        .wb_wr_n_bta   (wb_wr_n_bta),
        .wb_addr_bta   (wb_addr_bta),
        .iss_valid_alp (iss_valid_alp),
        .iss_valid_bta (iss_valid_bta),
        .rd1_addr_alp  (rd1_addr_alp),
        .rd2_addr_alp  (rd2_addr_alp),
        .rd1_addr_bta  (rd1_addr_bta),
        .rd2_addr_bta  (rd2_addr_bta),
        .iss_rd_alp    (iss_rd_alp),
        .iss_rd_bta    (iss_rd_bta),
        .iss_pld_alp   (iss_pld_alp),
        .iss_pld_bta   (iss_pld_bta),
        .issue_cnt     (issue_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_slot(input int s, input logic u1, input logic [4:0] r1,
                            input logic u2, input logic [4:0] r2,
                            input logic w, input logic [4:0] d, input logic [31:0] p);
        dec_use1[s]         = u1;
        dec_rs1[s*5 +: 5]   = r1;
        dec_use2[s]         = u2;
        dec_rs2[s*5 +: 5]   = r2;
        dec_wrd[s]          = w;
        dec_rd[s*5 +: 5]    = d;
        dec_pld[s*32 +: 32] = p;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; dec_valid = 2'b00;
        dec_rs1 = 10'd0; dec_rs2 = 10'd0; dec_rd = 10'd0;
        dec_use1 = 2'b00; dec_use2 = 2'b00; dec_wrd = 2'b00; dec_pld = 64'd0;
        wb_wr_n_alp = 1'b1; wb_wr_n_bta = 1'b1; wb_addr_alp = 5'd0; wb_addr_bta = 5'd0;
        #12;
        check("rst_ready", {31'd0, dec_ready}, 32'd1);
        check("rst_alp", {31'd0, iss_valid_alp}, 32'd0);
        check("rst_bta", {31'd0, iss_valid_bta}, 32'd0);
        check("rst_cnt", issue_cnt, 32'd0);
        check("rst_rd1", {27'd0, rd1_addr_alp}, 32'd0);
        tick();
        reset = 1'b1;

        // Independent pair: r1<-r2+r3, r4<-r5+r6
        set_slot(0, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 32'h0000_00A0);
        set_slot(1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 32'h0000_00B0);
        dec_valid = 2'b11;
        settle();
        check("t1_ready", {31'd0, dec_ready}, 32'd1);
        tick();
        dec_valid = 2'b00;
        settle();
        check("t1_alp", {31'd0, iss_valid_alp}, 32'd1);
        check("t1_bta", {31'd0, iss_valid_bta}, 32'd1);
        check("t1_rd1_alp", {27'd0, rd1_addr_alp}, 32'd2);
        check("t1_rd2_alp", {27'd0, rd2_addr_alp}, 32'd3);
        check("t1_rd1_bta", {27'd0, rd1_addr_bta}, 32'd5);
        check("t1_rd2_bta", {27'd0, rd2_addr_bta}, 32'd6);
        check("t1_rd_alp", {27'd0, iss_rd_alp}, 32'd1);
        check("t1_rd_bta", {27'd0, iss_rd_bta}, 32'd4);
        check("t1_pld_alp", iss_pld_alp, 32'h0000_00A0);
        check("t1_pld_bta", iss_pld_bta, 32'h0000_00B0);
        tick();
        check("t1_cnt", issue_cnt, 32'd2);
        check("t1_empty", {31'd0, iss_valid_alp}, 32'd0);

        // r7<-r1+r2 (r1 busy), r8<-r4 (r4 busy, rs2 unused)
        set_slot(0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 32'h0000_00C0);
        set_slot(1, 1'b1, 5'd4, 1'b0, 5'd9, 1'b1, 5'd8, 32'h0000_00D0);
        dec_valid = 2'b11;
        tick();
        dec_valid = 2'b00;
        settle();
        check("t2_stall_alp", {31'd0, iss_valid_alp}, 32'd0);
        check("t2_stall_ready", {31'd0, dec_ready}, 32'd0);
        check("t2_rd1_alp", {27'd0, rd1_addr_alp}, 32'd1);
        wb_wr_n_alp = 1'b0; wb_addr_alp = 5'd1;
        settle();
        check("t2_wb_alp", {31'd0, iss_valid_alp}, 32'd1);
        check("t2_wb_bta", {31'd0, iss_valid_bta}, 32'd0);
        check("t2_wb_rd", {27'd0, iss_rd_alp}, 32'd7);
        tick();
        wb_wr_n_alp = 1'b1;
        settle();
        check("t2_cmp_alp", {31'd0, iss_valid_alp}, 32'd0);
        check("t2_cmp_rd1", {27'd0, rd1_addr_alp}, 32'd4);
        check("t2_cmp_rd2", {27'd0, rd2_addr_alp}, 32'd0);
        check("t2_cnt", issue_cnt, 32'd3);
        wb_wr_n_bta = 1'b0; wb_addr_bta = 5'd4;
        settle();
        check("t2_bypass_alp", {31'd0, iss_valid_alp}, 32'd1);
        check("t2_bypass_pld", iss_pld_alp, 32'h0000_00D0);
        tick();
        wb_wr_n_bta = 1'b1;
        settle();
        check("t2_cnt2", issue_cnt, 32'd4);

        // Intra-pair RAW: r9<-r0+r0, r10<-r9
        set_slot(0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 32'h0000_00E0);
        set_slot(1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd10, 32'h0000_00F0);
        dec_valid = 2'b11;
        tick();
        dec_valid = 2'b00;
        settle();
        check("t3_alp", {31'd0, iss_valid_alp}, 32'd1);
        check("t3_hazard_bta", {31'd0, iss_valid_bta}, 32'd0);
        check("t3_rd1_r0", {27'd0, rd1_addr_alp}, 32'd0);
        tick();
        check("t3_stall", {31'd0, iss_valid_alp}, 32'd0);
        wb_wr_n_alp = 1'b0; wb_addr_alp = 5'd9;
        settle();
        check("t3_release", {31'd0, iss_valid_alp}, 32'd1);
        check("t3_rd", {27'd0, iss_rd_alp}, 32'd10);
        tick();
        wb_wr_n_alp = 1'b1;

        // r9 writer issuing with a coincident wb clear of r9, then WAW on r9
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0011);
        dec_valid = 2'b01;
        tick();
        dec_valid = 2'b00;
        wb_wr_n_bta = 1'b0; wb_addr_bta = 5'd9;
        settle();
        check("t4_set_alp", {31'd0, iss_valid_alp}, 32'd1);
        tick();
        wb_wr_n_bta = 1'b1;
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0022);
        dec_valid = 2'b01;
        tick();
        dec_valid = 2'b00;
        settle();
        check("t4_waw_stall", {31'd0, iss_valid_alp}, 32'd0);
        wb_wr_n_alp = 1'b0; wb_addr_alp = 5'd9;
        settle();
        check("t4_waw_release", {31'd0, iss_valid_alp}, 32'd1);
        tick();
        wb_wr_n_alp = 1'b1;
        check("t4_cnt", issue_cnt, 32'd8);

        // r0 writers and readers never stall
        set_slot(0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0000_0033);
        set_slot(1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 32'h0000_0044);
        dec_valid = 2'b11;
        tick();
        set_slot(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 32'h0000_0055);
        dec_valid = 2'b01;
        settle();
        check("t5_alp", {31'd0, iss_valid_alp}, 32'd1);
        check("t5_bta", {31'd0, iss_valid_bta}, 32'd1);
        check("t5_rd2_bta", {27'd0, rd2_addr_bta}, 32'd0);
        tick();
        dec_valid = 2'b00;
        settle();
        check("t5_r0_alp", {31'd0, iss_valid_alp}, 32'd1);
        tick();
        check("t5_cnt", issue_cnt, 32'd11);

        // Flush with a stalled full window and a pending pair
        set_slot(0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd12, 32'h0000_0066);
        set_slot(1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd13, 32'h0000_0077);
        dec_valid = 2'b11;
        tick();
        settle();
        check("t6_stall", {31'd0, iss_valid_alp}, 32'd0);
        set_slot(0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 5'd14, 32'h0000_0088);
        flush = 1'b1;
        wb_wr_n_alp = 1'b0; wb_addr_alp = 5'd7;
        settle();
        check("t6_flush_alp", {31'd0, iss_valid_alp}, 32'd0);
        tick();
        flush = 1'b0; wb_wr_n_alp = 1'b1; dec_valid = 2'b00;
        settle();
        check("t6_empty_alp", {31'd0, iss_valid_alp}, 32'd0);
        check("t6_empty_ready", {31'd0, dec_ready}, 32'd1);
        check("t6_cnt", issue_cnt, 32'd11);
        set_slot(0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd15, 32'h0000_0099);
        set_slot(1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd16, 32'h0000_00AA);
        dec_valid = 2'b11;
        tick();
        dec_valid = 2'b00;
        settle();
        check("t6_r7_cleared", {31'd0, iss_valid_alp}, 32'd1);
        check("t6_r8_busy", {31'd0, iss_valid_bta}, 32'd0);
        tick();
        check("t6_q_stall", {31'd0, iss_valid_alp}, 32'd0);

        // Reset mid-run
        reset = 1'b0;
        settle();
        check("t7_cnt", issue_cnt, 32'd0);
        check("t7_alp", {31'd0, iss_valid_alp}, 32'd0);
        check("t7_ready", {31'd0, dec_ready}, 32'd1);
        tick();
        reset = 1'b1;
        set_slot(0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd16, 32'h0000_00AA);
        dec_valid = 2'b01;
        tick();
        dec_valid = 2'b00;
        settle();
        check("t7_busy_cleared", {31'd0, iss_valid_alp}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
